// File: rtl/exc_ctl_pkg.sv
// Shared types and constants for the exception/interrupt controller.
package exc_pkg;

    // Controller mode: normal code, one-cycle interrupt entry, handler, locked after double fault.
    typedef enum logic [1:0] {
        USER  = 2'd0,
        TAKE  = 2'd1,
        SUPER = 2'd2,
        HALT  = 2'd3
    } exc_state_e;

    // Decoder Jump field encodings; only jump-register matters here (handler return).
    typedef enum logic [1:0] {
        JMP_NONE = 2'b00,
        JMP_J    = 2'b01,
        JMP_JR   = 2'b10,
        JMP_RSVD = 2'b11
    } jump_e;

    localparam logic [3:0] CAUSE_NONE     = 4'd0;
    localparam logic [3:0] CAUSE_ILLOP    = 4'd1;
    localparam logic [3:0] CAUSE_IRQ_BASE = 4'd2;

    // Index of the lowest set bit (0 when the vector is empty; callers check for that).
    function automatic logic [2:0] lowest_set(input logic [7:0] vec);
        logic [2:0] idx;
        idx = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (vec[i]) begin
                idx = 3'(i);
            end else begin
                idx = idx;
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/exc_ctl_if.sv
// Decoder-facing signal bundle of the exception controller.
// master = decoder/datapath side, slave = exception controller side.
interface exc_ctl_if #(
    parameter int NUM_IRQ = 4
);
    logic               illOp;
    logic [1:0]         jump;
    logic [31:0]        pc;
    logic               irq;
    logic               supervisorBit;
    logic               exc_take;
    logic [31:0]        exc_vector;
    logic               pc_hold;
    logic [31:0]        epc;
    logic [3:0]         cause;
    logic [NUM_IRQ-1:0] pending;

    modport master (
        output illOp, jump, pc,
        input  irq, supervisorBit, exc_take, exc_vector, pc_hold, epc, cause, pending
    );

    modport slave (
        input  illOp, jump, pc,
        output irq, supervisorBit, exc_take, exc_vector, pc_hold, epc, cause, pending
    );
endinterface

// File: rtl/exc_ctl_irq_sync.sv
// Per-line interrupt conditioner: multi-flop synchroniser followed by a
// rising-edge detector producing a one-cycle pulse.
module irq_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic async_in,
    output logic rise_pulse
);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   prev_q, prev_d;

    // Next-state of the synchroniser chain and the edge-detect history flop.
    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], async_in};
        prev_d = sync_q[SYNC_STAGES-1];
    end

    // Synchroniser and history registers, cleared by the synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= sync_d;
            prev_q <= prev_d;
        end
    end

    assign rise_pulse = sync_q[SYNC_STAGES-1] & ~prev_q;

endmodule

// File: rtl/exc_ctl.sv
// Exception/interrupt controller sitting in front of the instruction decoder.
// Latches interrupt edges, sequences USER -> TAKE -> SUPER entry, handles
// illegal opcodes and locks up in HALT on a fault inside the handler.
module exc_ctl
    import exc_pkg::*;
#(
    parameter int          NUM_IRQ     = 4,
    parameter logic [31:0] VEC_ADDR    = 32'h0000_0180,
    parameter int          SYNC_STAGES = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_IRQ-1:0] irq_in,
    exc_ctl_if.slave           dec
);

    logic [NUM_IRQ-1:0] rise_s;
    logic [NUM_IRQ-1:0] clear_s;
    logic [7:0]         pend_ext_s;
    logic [2:0]         low_idx_s;

    exc_state_e         state_q, state_d;
    logic [NUM_IRQ-1:0] pending_q, pending_d;
    logic [31:0]        epc_q, epc_d;
    logic [3:0]         cause_q, cause_d;

    for (genvar g = 0; g < NUM_IRQ; g++) begin : g_sync
        irq_sync #(
            .SYNC_STAGES(SYNC_STAGES)
        ) u_irq_sync (
            .clk       (clk),
            .reset     (reset),
            .async_in  (irq_in[g]),
            .rise_pulse(rise_s[g])
        );
    end

    assign pend_ext_s = 8'(pending_q);
    assign low_idx_s  = lowest_set(pend_ext_s);

    // Next-state, EPC/cause capture and pending bookkeeping.
    always_comb begin
        state_d = state_q;
        epc_d   = epc_q;
        cause_d = cause_q;
        clear_s = '0;
        case (state_q)
            USER: begin
                if (dec.illOp) begin
                    // Illegal op beats any pending interrupt; pending is left intact.
                    epc_d   = dec.pc;
                    cause_d = CAUSE_ILLOP;
                    state_d = SUPER;
                end else if (pending_q != '0) begin
                    state_d = TAKE;
                end else begin
                    state_d = USER;
                end
            end
            TAKE: begin
                if (pending_q != '0) begin
                    epc_d   = dec.pc;
                    cause_d = CAUSE_IRQ_BASE + {1'b0, low_idx_s};
                    clear_s = NUM_IRQ'(1'b1) << low_idx_s;
                    state_d = SUPER;
                end else begin
                    // Nothing to service: fall back to normal execution.
                    state_d = USER;
                end
            end
            SUPER: begin
                if (dec.illOp) begin
                    // Fault inside the handler: keep the original EPC for post-mortem.
                    cause_d = CAUSE_ILLOP;
                    state_d = HALT;
                end else if (dec.jump == JMP_JR) begin
                    state_d = USER;
                end else begin
                    state_d = SUPER;
                end
            end
            HALT: begin
                state_d = HALT;
            end
            default: begin
                state_d = USER;
            end
        endcase
        // A new edge on the same line as the one being serviced must not be lost.
        pending_d = (pending_q & ~clear_s) | rise_s;
    end

    // State, EPC, cause and pending registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= USER;
            pending_q <= '0;
            epc_q     <= 32'h0000_0000;
            cause_q   <= CAUSE_NONE;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            epc_q     <= epc_d;
            cause_q   <= cause_d;
        end
    end

    // Decoder controls decoded from the registered state; exc_take also follows illOp in USER.
    always_comb begin
        dec.irq           = 1'b0;
        dec.supervisorBit = 1'b0;
        dec.exc_take      = 1'b0;
        dec.pc_hold       = 1'b0;
        case (state_q)
            USER: begin
                dec.exc_take = dec.illOp;
            end
            TAKE: begin
                dec.irq      = 1'b1;
                dec.exc_take = 1'b1;
            end
            SUPER: begin
                dec.supervisorBit = 1'b1;
            end
            HALT: begin
                dec.supervisorBit = 1'b1;
                dec.pc_hold       = 1'b1;
            end
            default: begin
                dec.irq           = 1'b0;
                dec.supervisorBit = 1'b0;
                dec.exc_take      = 1'b0;
                dec.pc_hold       = 1'b0;
            end
        endcase
    end

    assign dec.exc_vector = VEC_ADDR;
    assign dec.epc        = epc_q;
    assign dec.cause      = cause_q;
    assign dec.pending    = pending_q;

endmodule
